// File: rtl/pio_hc595_pkg.sv
// Shared definitions for the PIO-to-74HC595 serializer: FSM state encoding and parameter legality.
// No logic of its own. No latency or backpressure applies.
package pio_hc595_pkg;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_SHIFT_LO = 2'd1;
    localparam logic [1:0] ST_SHIFT_HI = 2'd2;
    localparam logic [1:0] ST_LATCH    = 2'd3;

    localparam int CLK_DIV_MIN = 1;

    function automatic bit clk_div_legal(input int clk_div);
        return clk_div >= CLK_DIV_MIN;
    endfunction

endpackage

// File: rtl/pio_hc595_shifter_tick_div.sv
// Divide counter: tick pulses for one cycle every CLK_DIV cycles, counting from the last restart.
// Latency: first tick CLK_DIV cycles after restart. No backpressure; free-running.
module pio_tick_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic restart,
    output logic tick
);

    localparam int CNT_W = $clog2(CLK_DIV + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = (cnt_q == CNT_W'(CLK_DIV - 1));

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (restart || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pio_hc595_shifter.sv
// Serializes the PIO value onto a 74HC595 chain (SRCLK/SER/RCLK) whenever it differs from the last latched value.
// Latency: (2N+1)*CLK_DIV busy cycles per transfer. No backpressure; values changing mid-transfer collapse to the newest.
module pio_hc595_shifter
    import pio_hc595_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_DIV    = 4,
    parameter int MSB_FIRST  = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  sr_clk,
    output logic                  sr_data,
    output logic                  sr_latch,
    output logic                  busy
);

    localparam int BIT_CNT_W = $clog2(DATA_WIDTH);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_WIDTH - 1);

    if (!clk_div_legal(CLK_DIV)) begin : g_clk_div_check
        $error("pio_hc595_shifter: CLK_DIV must be >= 1");
    end

    logic [1:0]            state_q,        state_d;
    logic [DATA_WIDTH-1:0] shift_reg_q,    shift_reg_d;
    logic [DATA_WIDTH-1:0] shadow_q,       shadow_d;
    logic [BIT_CNT_W-1:0]  bit_cnt_q,      bit_cnt_d;
    logic                  init_pending_q, init_pending_d;
    logic                  sr_clk_q,       sr_clk_d;
    logic                  sr_data_q,      sr_data_d;
    logic                  sr_latch_q,     sr_latch_d;
    logic                  busy_q,         busy_d;
    logic                  tick;
    logic                  restart;
    logic                  cur_bit;

    assign restart = (state_d != state_q);

    pio_tick_div #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_div (
        .clk     (clk),
        .reset_n (reset_n),
        .restart (restart),
        .tick    (tick)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            shift_reg_q    <= '0;
            shadow_q       <= '0;
            bit_cnt_q      <= '0;
            init_pending_q <= 1'b1;
            sr_clk_q       <= 1'b0;
            sr_data_q      <= 1'b0;
            sr_latch_q     <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            shift_reg_q    <= shift_reg_d;
            shadow_q       <= shadow_d;
            bit_cnt_q      <= bit_cnt_d;
            init_pending_q <= init_pending_d;
            sr_clk_q       <= sr_clk_d;
            sr_data_q      <= sr_data_d;
            sr_latch_q     <= sr_latch_d;
            busy_q         <= busy_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        shift_reg_d    = shift_reg_q;
        shadow_d       = shadow_q;
        bit_cnt_d      = bit_cnt_q;
        init_pending_d = init_pending_q;
        case (state_q)
            ST_IDLE: begin
                // init_pending forces one transfer after reset so the chain leaves its power-up state.
                if ((data_in != shadow_q) || init_pending_q) begin
                    shift_reg_d    = data_in;
                    shadow_d       = data_in;
                    init_pending_d = 1'b0;
                    bit_cnt_d      = '0;
                    state_d        = ST_SHIFT_LO;
                end
            end
            ST_SHIFT_LO: begin
                if (tick) begin
                    state_d = ST_SHIFT_HI;
                end
            end
            ST_SHIFT_HI: begin
                if (tick) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = ST_LATCH;
                    end else begin
                        shift_reg_d = (MSB_FIRST != 0) ? {shift_reg_q[DATA_WIDTH-2:0], 1'b0}
                                                       : {1'b0, shift_reg_q[DATA_WIDTH-1:1]};
                        bit_cnt_d   = bit_cnt_q + 1'b1;
                        state_d     = ST_SHIFT_LO;
                    end
                end
            end
            ST_LATCH: begin
                if (tick) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Pins are registered from the next state so they line up with the state they describe.
    always_comb begin
        cur_bit    = (MSB_FIRST != 0) ? shift_reg_d[DATA_WIDTH-1] : shift_reg_d[0];
        sr_clk_d   = (state_d == ST_SHIFT_HI);
        sr_latch_d = (state_d == ST_LATCH);
        busy_d     = (state_d != ST_IDLE);
        sr_data_d  = 1'b0;
        if ((state_d == ST_SHIFT_LO) || (state_d == ST_SHIFT_HI)) begin
            sr_data_d = cur_bit;
        end
    end

    assign sr_clk   = sr_clk_q;
    assign sr_data  = sr_data_q;
    assign sr_latch = sr_latch_q;
    assign busy     = busy_q;

endmodule

// File: doc/pio_hc595_shifter.md
# pio_hc595_shifter

Serializes the 8-bit value driven by the Avalon output PIO (`out_port`) onto an external 74HC595-style shift register chain through three pins: shift clock, serial data and storage latch. The block sits directly downstream of the PIO on the same clock. It watches its parallel input and starts a complete shift-and-latch transfer whenever the value differs from the last value latched out. Software writes the PIO register and the external pins follow with no further CPU involvement.

## Interface
- `DATA_WIDTH`, default 8: bits per transfer; matches the PIO width.
- `CLK_DIV`, default 4: `clk` cycles per half-period of `sr_clk`; legal range ≥1.
- `MSB_FIRST`, default 1: 1 shifts bit `DATA_WIDTH-1` first, 0 shifts bit 0 first.
- `clk`  in  1: system clock. Same clock as the PIO. One clock domain; reset is synchronous and active-low.
- `reset_n`  in  1: synchronous, active-low reset.
- `data_in`  in  DATA_WIDTH: parallel value, wired to the PIO `out_port`; synchronous to `clk`.
- `sr_clk`  out  1: shift clock to the 595 (SRCLK); data is sampled on its rising edge.
- `sr_data`  out  1: serial data to the 595 (SER).
- `sr_latch`  out  1: storage-register strobe to the 595 (RCLK); active high.
- `busy`  out  1: high while a transfer is in progress.

## Operation
- Reset (`reset_n`=0 at a `clk` edge):
  - `sr_clk`, `sr_data`, `sr_latch` and `busy` go to 0.
  - State goes to IDLE; `shadow` clears to 0.
  - `init_pending` sets to 1.
- States: IDLE, SHIFT_LO, SHIFT_HI, LATCH.
- IDLE:
  - A transfer starts when `data_in != shadow` or `init_pending`=1.
  - On start: `shift_reg` and `shadow` load `data_in`, `init_pending` clears, `bit_cnt` loads 0, state goes to SHIFT_LO.
  - The `init_pending` rule means the first transfer after reset is sent even when `data_in`=0, so the external chain is defined.
- SHIFT_LO:
  - `sr_clk`=0; `sr_data` = current bit (the MSB or LSB of `shift_reg`, per `MSB_FIRST`).
  - After `CLK_DIV` cycles, go to SHIFT_HI.
- SHIFT_HI:
  - `sr_clk`=1; `sr_data` is held.
  - After `CLK_DIV` cycles: if `bit_cnt`==`DATA_WIDTH-1`, go to LATCH; otherwise shift `shift_reg` by one, increment `bit_cnt`, and go to SHIFT_LO.
- LATCH:
  - `sr_clk`=0, `sr_latch`=1 for `CLK_DIV` cycles, then go to IDLE with `sr_latch`=0.
- `busy`=1 in every state except IDLE.
- Changes to `data_in` during a transfer are not sampled. On return to IDLE the block compares again, so only the newest value is sent and intermediate values are dropped by design.
- `sr_data` is 0 in IDLE.
- Reset in the middle of a transfer aborts immediately with the reset values above; the partially shifted data is never latched.
- Widths and counters:
  - `bit_cnt` is $clog2(DATA_WIDTH) bits wide.
  - The divide counter is $clog2(CLK_DIV+1) bits wide and reloads to 0 on every state change.

## Timing
- Let cycle 0 be the `clk` edge at which IDLE sees the start condition. Let D = `CLK_DIV` and N = `DATA_WIDTH`.
- All outputs are registered; there is no combinational path from `data_in` to any output.
- Bit k (k = 0 … N-1):
  - `sr_data` is valid from cycle 1+2kD.
  - `sr_clk` rises at cycle 1+(2k+1)D.
  - `sr_data` changes only at an `sr_clk` falling edge, giving D cycles of setup and D cycles of hold.
- `sr_latch` is high during cycles 1+2ND through 1+2ND+D-1.
- `busy` is high during cycles 1 through (2N+1)D.
- IDLE is re-entered at cycle 1+(2N+1)D. A new start can be detected in that same cycle.
- For N=8, D=4: 68 busy cycles; the latch pulse spans cycles 65–68.

## Structure
- Shared package `pio_hc595_pkg` holds:
  - the state encoding localparams (`ST_IDLE`=2'd0, `ST_SHIFT_LO`=2'd1, `ST_SHIFT_HI`=2'd2, `ST_LATCH`=2'd3);
  - the `CLK_DIV` minimum-value check.
- One sub-module, `pio_tick_div`:
  - Parameterized by `CLK_DIV`.
  - Inputs `clk`, `reset_n`, `restart`; output `tick`, a one-cycle pulse every `CLK_DIV` cycles after `restart`.
  - The FSM advances on `tick`.
- The top level holds the FSM, `shift_reg`, `bit_cnt`, `shadow`, `init_pending` and the output registers.

## Test plan
- Release reset with `data_in`=8'h00 (D=4) → one transfer of eight 0 bits; `sr_latch` high during cycles 65–68; `busy` low from cycle 69; no further activity.
- Set `data_in`=8'hA5 with `MSB_FIRST`=1 → `sr_data` sampled at the rising edges of `sr_clk` reads 1,0,1,0,0,1,0,1; exactly 8 `sr_clk` rising edges, then one latch pulse.
- Same stimulus with `MSB_FIRST`=0 → sampled sequence 1,0,1,0,0,1,0,1 reversed per bit order (LSB first: 1,0,1,0,0,1,0,1 for 8'hA5).
- Hold `data_in`=8'h3C after its transfer completes → no further `sr_clk` edges and `busy` stays 0 for 500 cycles.
- During a transfer of 8'h11, step `data_in` through 8'h22 and then 8'h33 → the 8'h11 transfer completes; the next transfer is 8'h33 only; 8'h22 never appears on the pins.
- Pulse `reset_n` low for one cycle after bit 3 of an 8'hFF transfer → no latch pulse; all outputs read 0 the next cycle; a full 8'hFF transfer then follows, triggered by `init_pending`.
